// File: rtl/led_pulse_stretcher_pkg.sv
// Shared types for the LED pulse stretcher.
// Provides the FSM state type and a small integer helper for width derivation.
package led_pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_GAP
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_pulse_stretcher_event_edge_detect.sv
// Registered rising-edge detector.
// Ports: clk, rst (sync, active-high), level in, rise out (level & ~previous level).
module event_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= RESET_VAL;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches event strobes into visible LED pulses with a dark gap between them.
// Ports: i_Clk, i_Rst (sync, active-high), i_Event in; o_LED, o_Busy, o_Overflow registered out.
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int c_ON_TIME     = 2500000,
    parameter int c_OFF_TIME    = 1250000,
    parameter int c_MAX_PENDING = 7
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Event,
    output logic o_LED,
    output logic o_Busy,
    output logic o_Overflow
);

    localparam int TIMER_MAX = max_int(c_ON_TIME, c_OFF_TIME);
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam int PEND_W    = $clog2(c_MAX_PENDING + 1);

    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(c_ON_TIME - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(c_OFF_TIME - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(c_MAX_PENDING);

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic [PEND_W-1:0]   pending;
    logic                rise;
    logic                gap_done;
    logic                consume;
    logic                queue_in;

    // Previous level resets high so a level held through reset is not an event.
    event_edge_detect #(
        .RESET_VAL (1'b1)
    ) u_edge (
        .clk   (i_Clk),
        .rst   (i_Rst),
        .level (i_Event),
        .rise  (rise)
    );

    // consume: the last gap cycle starts a new pulse, taking either a
    // queued event or the edge arriving right now.
    always_comb begin
        gap_done = 1'b0;
        consume  = 1'b0;
        queue_in = 1'b0;
        gap_done = (state == ST_GAP) && (timer == OFF_LAST);
        consume  = gap_done && ((pending != '0) || rise);
        queue_in = rise && (state != ST_IDLE);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            pending    <= '0;
            o_LED      <= 1'b0;
            o_Busy     <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            o_Overflow <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state  <= ST_ON;
                        timer  <= '0;
                        o_LED  <= 1'b1;
                        o_Busy <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (timer == ON_LAST) begin
                        state <= ST_GAP;
                        timer <= '0;
                        o_LED <= 1'b0;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        timer <= '0;
                        if (consume) begin
                            state <= ST_ON;
                            o_LED <= 1'b1;
                        end else begin
                            state  <= ST_IDLE;
                            o_Busy <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    timer  <= '0;
                    o_LED  <= 1'b0;
                    o_Busy <= 1'b0;
                end
            endcase

            // An edge that is consumed in the same cycle leaves the queue
            // unchanged, so it can never overflow.
            if (queue_in && !consume) begin
                if (pending == PEND_MAX) begin
                    o_Overflow <= 1'b1;
                end else begin
                    pending <= pending + PEND_W'(1);
                end
            end else if (consume && !queue_in) begin
                pending <= pending - PEND_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Self-checking bench for led_pulse_stretcher against a pulse-schedule model.
// Drives directed scenarios and random event traffic with occasional resets.
module tb_led_pulse_stretcher;

    localparam int ON   = 4;
    localparam int OFF  = 2;
    localparam int MAXP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ev  = 1'b0;
    logic led;
    logic busy;
    logic ovf;

    always #5 clk = ~clk;

    led_pulse_stretcher #(
        .c_ON_TIME     (ON),
        .c_OFF_TIME    (OFF),
        .c_MAX_PENDING (MAXP)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Event    (ev),
        .o_LED      (led),
        .o_Busy     (busy),
        .o_Overflow (ovf)
    );

    int n_vec = 0;
    int n_bad = 0;
    longint cyc = 0;

    // Model: a pulse is described by its first lit cycle m_s; it is lit
    // for [m_s, m_s+ON) and dark for [m_s+ON, m_s+ON+OFF).
    bit     m_active = 1'b0;
    longint m_s      = 0;
    int     m_pend   = 0;
    bit     m_prev   = 1'b1;
    bit     m_ovf    = 1'b0;

    int led_cnt  = 0;
    int busy_cnt = 0;
    int ovf_cnt  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    task automatic win_clear();
        led_cnt  = 0;
        busy_cnt = 0;
        ovf_cnt  = 0;
    endtask

    task automatic step(input logic r, input logic e);
        bit edge_v;
        bit exp_led;
        @(negedge clk);
        rst = r;
        ev  = e;
        @(posedge clk);
        if (r) begin
            m_active = 1'b0;
            m_pend   = 0;
            m_prev   = 1'b1;
            m_ovf    = 1'b0;
        end else begin
            edge_v = e & ~m_prev;
            m_prev = e;
            m_ovf  = 1'b0;
            if (!m_active) begin
                if (edge_v) begin
                    m_active = 1'b1;
                    m_s      = cyc + 1;
                end
            end else if (cyc == m_s + ON + OFF - 1) begin
                if (m_pend > 0) begin
                    m_s = cyc + 1;
                    if (!edge_v) m_pend--;
                end else if (edge_v) begin
                    m_s = cyc + 1;
                end else begin
                    m_active = 1'b0;
                end
            end else if (edge_v) begin
                if (m_pend == MAXP) m_ovf = 1'b1;
                else m_pend++;
            end
        end
        #1;
        exp_led = m_active && (cyc + 1 >= m_s) && (cyc + 1 < m_s + ON);
        chk("led", int'(led), int'(exp_led));
        chk("busy", int'(busy), int'(m_active));
        chk("ovf", int'(ovf), int'(m_ovf));
        led_cnt  += int'(led);
        busy_cnt += int'(busy);
        ovf_cnt  += int'(ovf);
        cyc++;
    endtask

    initial begin
        // reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

        // single strobe
        win_clear();
        step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("strobe_led_cycles", led_cnt, 4);
        chk("strobe_busy_cycles", busy_cnt, 6);
        chk("strobe_ovf", ovf_cnt, 0);

        // held level
        win_clear();
        for (int i = 0; i < 31; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("level_led_cycles", led_cnt, 4);
        chk("level_busy_cycles", busy_cnt, 6);

        // queueing: edges every other cycle, four total
        win_clear();
        for (int i = 0; i < 40; i++) step(1'b0, (i < 7) && (i % 2 == 0));
        chk("queue_led_cycles", led_cnt, 16);
        chk("queue_busy_cycles", busy_cnt, 24);
        chk("queue_ovf", ovf_cnt, 0);

        // overflow plus edge landing on a full-queue consume
        win_clear();
        for (int i = 0; i < 60; i++) step(1'b0, (i < 13) && (i % 2 == 0));
        chk("ovf_led_cycles", led_cnt, 24);
        chk("ovf_pulses", ovf_cnt, 1);

        // reset mid-ON with the event level held across reset
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("midrst_led", int'(led), 0);
        chk("midrst_busy", int'(busy), 0);
        win_clear();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        chk("held_after_rst", led_cnt, 0);
        step(1'b0, 1'b0);
        win_clear();
        step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk("rearm_led_cycles", led_cnt, 4);

        // random traffic with varying density and rare resets
        for (int seg = 0; seg < 60; seg++) begin
            int dens;
            dens = $urandom_range(1, 9);
            for (int i = 0; i < 50; i++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 9) < dens);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
